// File: rtl/usb_rcu.sv
// usb_rcu: receive control unit; walks SYNC/PID/payload/EOP and tracks TOKEN -> DATA -> HANDSHAKE.
// Optional CRC5/CRC16 checking is compiled in when USB_RCU_CRC_CHECK_EN is defined.
module usb_rcu #(
    parameter int unsigned DATA_BYTES = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'h80
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        d_edge,
    input  logic        byte_received,
    input  logic [7:0]  rcv_byte,
    input  logic        eop,
    output logic        receiving,
    output logic [3:0]  rcv_pid,
    output logic [63:0] rcv_data,
    output logic        token_valid,
    output logic        data_valid,
    output logic        handshake_ack,
    output logic        rcv_error,
    output logic [2:0]  err_code
);

    typedef enum logic [3:0] {
        IDLE, SYNC, PID, TOK_CRC, DATA, CRC_LO, CRC_HI, WAIT_EOP, DONE, ERROR
    } state_t;

    typedef enum logic [1:0] {PKT_TOKEN, PKT_DATA, PKT_HS} pkt_t;

    localparam logic [2:0] ERR_SYNC  = 3'd1;
    localparam logic [2:0] ERR_PID   = 3'd2;
    localparam logic [2:0] ERR_ABORT = 3'd3;
    localparam logic [2:0] ERR_EOP   = 3'd4;
    localparam logic [2:0] ERR_SEQ   = 3'd5;
    localparam logic [2:0] ERR_CRC   = 3'd6;
    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES - 1);

    state_t     state, state_n;
    pkt_t       exp_q, pkt_q, pid_type;
    logic [2:0] byte_cnt;
    logic [2:0] err_n;
    logic       pid_legal, accept_pid, wr_data, go_err, crc_ok;

    always_comb begin
        pid_legal = 1'b0;
        pid_type  = PKT_TOKEN;
        if (rcv_byte[7:4] == ~rcv_byte[3:0]) begin
            case (rcv_byte)
                8'h1E: begin pid_legal = 1'b1; pid_type = PKT_TOKEN; end
                8'h3C: begin pid_legal = 1'b1; pid_type = PKT_DATA;  end
                8'h2D: begin pid_legal = 1'b1; pid_type = PKT_HS;    end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        go_err     = 1'b0;
        err_n      = 3'd0;
        accept_pid = 1'b0;
        wr_data    = 1'b0;
        case (state)
            IDLE:        if (d_edge) state_n = SYNC;
            DONE, ERROR: state_n = IDLE;
            default: begin
                // Abort beats eop, and eop beats a byte arriving in the same cycle.
                if (d_edge) begin
                    go_err = 1'b1;
                    err_n  = ERR_ABORT;
                end else if (eop) begin
                    if (state != WAIT_EOP) begin
                        go_err = 1'b1;
                        err_n  = ERR_ABORT;
                    end else if (!crc_ok) begin
                        go_err = 1'b1;
                        err_n  = ERR_CRC;
                    end else begin
                        state_n = DONE;
                    end
                end else if (byte_received) begin
                    case (state)
                        SYNC: begin
                            if (rcv_byte == SYNC_BYTE) state_n = PID;
                            else begin
                                go_err = 1'b1;
                                err_n  = ERR_SYNC;
                            end
                        end
                        PID: begin
                            if (!pid_legal) begin
                                go_err = 1'b1;
                                err_n  = ERR_PID;
                            end else if (pid_type != PKT_TOKEN && pid_type != exp_q) begin
                                go_err = 1'b1;
                                err_n  = ERR_SEQ;
                            end else begin
                                accept_pid = 1'b1;
                                case (pid_type)
                                    PKT_TOKEN: state_n = TOK_CRC;
                                    PKT_DATA:  state_n = DATA;
                                    default:   state_n = WAIT_EOP;
                                endcase
                            end
                        end
                        TOK_CRC: state_n = WAIT_EOP;
                        DATA: begin
                            wr_data = 1'b1;
                            if (byte_cnt == LAST_BYTE) state_n = CRC_LO;
                        end
                        CRC_LO: state_n = CRC_HI;
                        CRC_HI: state_n = WAIT_EOP;
                        WAIT_EOP: begin
                            go_err = 1'b1;
                            err_n  = ERR_EOP;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (go_err) state_n = ERROR;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exp_q     <= PKT_TOKEN;
            pkt_q     <= PKT_TOKEN;
            byte_cnt  <= 3'd0;
            rcv_pid   <= 4'd0;
            rcv_data  <= 64'd0;
            rcv_error <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            if (state == IDLE && d_edge) begin
                rcv_error <= 1'b0;
                err_code  <= 3'd0;
            end
            if (go_err) begin
                rcv_error <= 1'b1;
                err_code  <= err_n;
                exp_q     <= PKT_TOKEN;
            end
            if (accept_pid) begin
                rcv_pid  <= rcv_byte[3:0];
                pkt_q    <= pid_type;
                byte_cnt <= 3'd0;
                if (pid_type == PKT_DATA) rcv_data <= 64'd0;
            end
            if (wr_data) begin
                rcv_data[{byte_cnt, 3'b000} +: 8] <= rcv_byte;
                byte_cnt <= byte_cnt + 3'd1;
            end
            if (state == DONE) begin
                case (pkt_q)
                    PKT_TOKEN: exp_q <= PKT_DATA;
                    PKT_DATA:  exp_q <= PKT_HS;
                    default:   exp_q <= PKT_TOKEN;
                endcase
            end
        end
    end

`ifdef USB_RCU_CRC_CHECK_EN
    logic [4:0]  crc5_q;
    logic [15:0] crc16_q, crc_rx_q;

    // Bit-serial LFSR steps, LSB of each byte first as it was on the wire.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[4] ^ b[i]) r = {r[3:0], 1'b0} ^ 5'h05;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc5_q   <= 5'h1F;
            crc16_q  <= 16'hFFFF;
            crc_rx_q <= 16'd0;
        end else begin
            if (accept_pid) begin
                crc5_q  <= crc5_byte(5'h1F, rcv_byte);
                crc16_q <= 16'hFFFF;
            end
            if (wr_data) crc16_q <= crc16_byte(crc16_q, rcv_byte);
            if (byte_received) begin
                if (state == TOK_CRC) crc_rx_q       <= {11'd0, rcv_byte[4:0]};
                if (state == CRC_LO)  crc_rx_q[7:0]  <= rcv_byte;
                if (state == CRC_HI)  crc_rx_q[15:8] <= rcv_byte;
            end
        end
    end

    always_comb begin
        case (pkt_q)
            PKT_TOKEN: crc_ok = (~crc5_q == crc_rx_q[4:0]);
            PKT_DATA:  crc_ok = (~crc16_q == crc_rx_q);
            default:   crc_ok = 1'b1;
        endcase
    end
`else
    assign crc_ok = 1'b1;
`endif

    assign receiving     = !(state inside {IDLE, DONE, ERROR});
    assign token_valid   = (state == DONE) && (pkt_q == PKT_TOKEN);
    assign data_valid    = (state == DONE) && (pkt_q == PKT_DATA);
    assign handshake_ack = (state == DONE) && (pkt_q == PKT_HS);

endmodule

// File: tb/tb_usb_rcu.sv
// Bench for usb_rcu: packet-level reference model checked every cycle, directed literal checks, random packets.
`timescale 1ns/1ps
module tb_usb_rcu;
    localparam int DB = 8;
`ifdef USB_RCU_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0, n_rst = 1'b1;
    logic        d_edge = 1'b0, byte_received = 1'b0, eop = 1'b0;
    logic [7:0]  rcv_byte = 8'd0;
    logic        receiving, token_valid, data_valid, handshake_ack, rcv_error;
    logic [3:0]  rcv_pid;
    logic [63:0] rcv_data;
    logic [2:0]  err_code;

    usb_rcu #(.DATA_BYTES(DB), .SYNC_BYTE(8'h80)) dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_received(byte_received),
        .rcv_byte(rcv_byte), .eop(eop), .receiving(receiving), .rcv_pid(rcv_pid),
        .rcv_data(rcv_data), .token_valid(token_valid), .data_valid(data_valid),
        .handshake_ack(handshake_ack), .rcv_error(rcv_error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as polynomial division over the message bits, LSB of each byte first, init ones, inverted.
    function automatic logic [15:0] crc_calc(input int w, input logic [15:0] poly, input logic [7:0] msg[$]);
        logic [15:0] c, mask;
        bit top;
        mask = 16'((32'd1 << w) - 1);
        c = mask;
        foreach (msg[i]) begin
            for (int j = 0; j < 8; j++) begin
                top = c[w-1];
                c = (c << 1) & mask;
                if (top ^ msg[i][j]) c = c ^ poly;
            end
        end
        return ~c & mask;
    endfunction

    // Reference model: packet kind 0=TOKEN 1=DATA 2=HANDSHAKE; bytes of the packet kept in a queue.
    int          m_exp, m_pkt;
    bit          m_inpkt, m_cool, m_tok, m_dv, m_hs, m_err;
    logic [7:0]  m_bytes[$];
    logic [3:0]  m_pid;
    logic [63:0] m_data;
    logic [2:0]  m_code;

    function automatic int pid_kind(input logic [7:0] b);
        case (b)
            8'h1E:   return 0;
            8'h3C:   return 1;
            8'h2D:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int need_bytes(input int k);
        return (k == 0) ? 1 : (k == 1) ? DB + 2 : 0;
    endfunction

    function automatic bit crc_good();
        logic [7:0] pl[$];
        logic [15:0] c;
        if (m_pkt == 0) begin
            pl.push_back(m_bytes[1]);
            c = crc_calc(5, 16'h0005, pl);
            return c[4:0] == m_bytes[2][4:0];
        end
        if (m_pkt == 1) begin
            for (int i = 0; i < DB; i++) pl.push_back(m_bytes[2+i]);
            c = crc_calc(16, 16'h8005, pl);
            return c == {m_bytes[DB+3], m_bytes[DB+2]};
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_exp = 0; m_pkt = 0; m_inpkt = 0; m_cool = 0;
        m_tok = 0; m_dv = 0; m_hs = 0; m_err = 0;
        m_bytes.delete(); m_pid = 4'd0; m_data = 64'd0; m_code = 3'd0;
    endtask

    task automatic m_fail(input int code);
        m_err = 1; m_code = 3'(code); m_exp = 0; m_inpkt = 0; m_cool = 1;
    endtask

    task automatic m_byte(input logic [7:0] b);
        int n;
        int k;
        n = m_bytes.size();
        if (n == 0) begin
            if (b != 8'h80) begin m_fail(1); return; end
        end else if (n == 1) begin
            k = pid_kind(b);
            if (k < 0) begin m_fail(2); return; end
            if (k != 0 && k != m_exp) begin m_fail(5); return; end
            m_pkt = k;
            m_pid = b[3:0];
            if (k == 1) m_data = 64'd0;
        end else begin
            if (n - 2 >= need_bytes(m_pkt)) begin m_fail(4); return; end
            if (m_pkt == 1 && n - 2 < DB) m_data[8*(n-2) +: 8] = b;
        end
        m_bytes.push_back(b);
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) m_reset();
        else begin
            m_tok = 0; m_dv = 0; m_hs = 0;
            if (m_cool) m_cool = 0;
            else if (!m_inpkt) begin
                if (d_edge) begin
                    m_inpkt = 1; m_bytes.delete(); m_err = 0; m_code = 3'd0;
                end
            end else if (d_edge) m_fail(3);
            else if (eop) begin
                if (m_bytes.size() >= 2 && m_bytes.size() - 2 == need_bytes(m_pkt)) begin
                    if (CRC_EN && !crc_good()) m_fail(6);
                    else begin
                        m_tok = (m_pkt == 0); m_dv = (m_pkt == 1); m_hs = (m_pkt == 2);
                        m_exp = (m_pkt + 1) % 3; m_inpkt = 0; m_cool = 1;
                    end
                end else m_fail(3);
            end else if (byte_received) m_byte(rcv_byte);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("receiving", 64'(receiving), 64'(m_inpkt));
            chk("rcv_pid", 64'(rcv_pid), 64'(m_pid));
            chk("rcv_data", rcv_data, m_data);
            chk("token_valid", 64'(token_valid), 64'(m_tok));
            chk("data_valid", 64'(data_valid), 64'(m_dv));
            chk("handshake_ack", 64'(handshake_ack), 64'(m_hs));
            chk("rcv_error", 64'(rcv_error), 64'(m_err));
            chk("err_code", 64'(err_code), 64'(m_code));
        end
    end

    task automatic step(input bit de, input bit br, input logic [7:0] b, input bit e);
        d_edge = de; byte_received = br; rcv_byte = b; eop = e;
        @(posedge clk); #2;
        d_edge = 0; byte_received = 0; eop = 0;
    endtask

    task automatic make_pkt(input int k, input bit fixed, output logic [7:0] q[$]);
        logic [7:0] pl[$];
        logic [15:0] c;
        q = {8'h80};
        case (k)
            0: begin
                q.push_back(8'h1E);
                pl.push_back(8'h1E);
                c = crc_calc(5, 16'h0005, pl);
                q.push_back({3'($urandom), c[4:0]});
            end
            1: begin
                q.push_back(8'h3C);
                for (int i = 0; i < DB; i++) pl.push_back(fixed ? 8'(i + 1) : 8'($urandom));
                q = {q, pl};
                c = crc_calc(16, 16'h8005, pl);
                q.push_back(c[7:0]);
                q.push_back(c[15:8]);
            end
            default: q.push_back(8'h2D);
        endcase
    endtask

    task automatic send(input logic [7:0] q[$], input int gap_max, input bit eop_with_byte);
        step(0, 0, 8'd0, 0);
        step(1, 0, 8'd0, 0);
        foreach (q[i]) begin
            step(0, 1, q[i], 0);
            repeat ($urandom_range(0, gap_max)) step(0, 0, 8'd0, 0);
        end
        if (eop_with_byte) step(0, 1, 8'hAA, 1);
        else               step(0, 0, 8'd0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int kind, k, pos, hi;

        #1 n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_data", rcv_data, 64'd0);
        chk("reset_ctrl", 64'({receiving, rcv_pid, token_valid, data_valid, handshake_ack, rcv_error, err_code}), 64'd0);
        n_rst = 1'b1;
        cmp_en = 1'b1;

        make_pkt(0, 1, q); send(q, 0, 0);
        chk("tok_valid", 64'(token_valid), 64'd1);
        chk("tok_pid", 64'(rcv_pid), 64'hE);
        chk("tok_noerr", 64'(rcv_error), 64'd0);
        step(0, 0, 8'd0, 0);
        chk("tok_pulse_end", 64'(token_valid), 64'd0);

        make_pkt(1, 1, q); send(q, 0, 0);
        chk("data_valid", 64'(data_valid), 64'd1);
        chk("data_word", rcv_data, 64'h0807060504030201);
        make_pkt(2, 1, q); send(q, 0, 0);
        chk("hs_ack", 64'(handshake_ack), 64'd1);
        chk("data_stable", rcv_data, 64'h0807060504030201);

        send('{8'h80, 8'h1F}, 0, 0);
        chk("badpid_err", 64'(rcv_error), 64'd1);
        chk("badpid_code", 64'(err_code), 64'd2);
        chk("badpid_nostrobe", 64'({token_valid, data_valid, handshake_ack}), 64'd0);
        step(1, 0, 8'd0, 0);
        chk("clear_err", 64'({rcv_error, err_code}), 64'd0);
        chk("recv_high", 64'(receiving), 64'd1);
        step(0, 0, 8'd0, 1);
        chk("eop_in_sync", 64'(err_code), 64'd3);

        make_pkt(2, 1, q); send(q, 0, 0);
        chk("seq_code", 64'(err_code), 64'd5);
        make_pkt(0, 1, q); send(q, 0, 0);
        chk("seq_tok_after", 64'(token_valid), 64'd1);
        make_pkt(0, 1, q); send(q, 0, 0);
        chk("tok_restart", 64'(token_valid), 64'd1);

        send('{8'h80, 8'h3C, 8'h01, 8'h02, 8'h03}, 0, 0);
        chk("early_eop_code", 64'(err_code), 64'd3);
        chk("early_eop_data", rcv_data, 64'h0000000000030201);

        make_pkt(0, 1, q); q.push_back(8'h55); send(q, 0, 0);
        chk("extra_byte_code", 64'(err_code), 64'd4);

        make_pkt(0, 1, q); send(q, 0, 1);
        chk("eop_beats_byte", 64'(token_valid), 64'd1);

`ifdef USB_RCU_CRC_CHECK_EN
        make_pkt(1, 1, q); q[q.size()-1] ^= 8'h10; send(q, 0, 0);
        chk("crc_code", 64'(err_code), 64'd6);
        chk("crc_nostrobe", 64'(data_valid), 64'd0);
`endif

        make_pkt(0, 1, q); send(q, 0, 0);
        step(0, 0, 8'd0, 0);
        step(1, 0, 8'd0, 0);
        step(0, 1, 8'h80, 0); step(0, 1, 8'h3C, 0); step(0, 1, 8'h11, 0); step(0, 1, 8'h22, 0);
        n_rst = 1'b0;
        #1;
        chk("midrst_data", rcv_data, 64'd0);
        chk("midrst_ctrl", 64'({receiving, rcv_pid, token_valid, data_valid, handshake_ack, rcv_error, err_code}), 64'd0);
        @(posedge clk); #2;
        n_rst = 1'b1;

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 11);
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : m_exp;
            make_pkt(k, 0, q);
            case (kind)
                0: q[0] = 8'($urandom_range(0, 127));
                1: q[1] = 8'($urandom);
                2: begin hi = $urandom_range(0, q.size() - 2); q = q[0:hi]; end
                3: q.push_back(8'($urandom));
                6: q[q.size()-1] ^= 8'h01;
                default: ;
            endcase
            pos = $urandom_range(0, q.size() - 1);
            if ($urandom_range(0, 3) == 0) step(0, 1, 8'($urandom), 0);
            step(1, 0, 8'd0, 0);
            foreach (q[i]) begin
                if (kind == 4 && i == pos) step(1, 0, 8'd0, 0);
                step(0, 1, q[i], 0);
                repeat ($urandom_range(0, 2)) step(0, 0, 8'd0, 0);
            end
            if (kind == 5)      step(0, 1, 8'($urandom), 1);
            else if (kind != 7) step(0, 0, 8'd0, 1);
            repeat ($urandom_range(1, 3)) step(0, 0, 8'd0, 0);
        end

        repeat (3) step(0, 0, 8'd0, 0);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
